// File: rtl/uci_pkg.sv
// Shared UCI definitions: line terminator characters and the TX output state encoding.
package uci_pkg;

    localparam logic [7:0] NEW_LINE     = 8'h0A;
    localparam logic [7:0] CARRIAGE_RET = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_EOL_CR = 2'd2,
        ST_EOL_LF = 2'd3
    } uci_tx_state_t;

    // Index width for a channel count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: round-robin from (last + 1) or fixed lowest-index priority.
module rr_arbiter
    import uci_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int PRIORITY_MODE = 0,
    localparam int IDX_W        = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_vld
);

    int cand;

    // Walk the search order backwards so the first requester in order is the last one written.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (PRIORITY_MODE != 0)
                cand = k - 1;
            else
                cand = (int'(last) + k) % NUM_CH;
            if (req[cand]) begin
                grant_idx = IDX_W'(cand);
                grant_vld = 1'b1;
            end
        end
        grant_oh = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/uci_tx_mux.sv
// Multi-channel UCI line transmitter: one slot per channel, arbitrated and serialised with a terminator.
// Optional CR before LF when UCI_TX_CRLF_EN is defined.
module uci_tx_mux
    import uci_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int MAX_LEN       = 64,
    parameter int PRIORITY_MODE = 0,
    localparam int IDX_W        = idx_width(NUM_CH)
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [NUM_CH-1:0][MAX_LEN-1:0][7:0]  line_in,
    input  logic [NUM_CH-1:0]                    line_in_valid,
    output logic [NUM_CH-1:0]                    line_in_ready,
    output logic [7:0]                           char_out,
    output logic                                 char_out_valid,
    input  logic                                 char_out_ready,
    output logic                                 busy,
    output logic [IDX_W-1:0]                     active_ch,
    output logic [15:0]                          lines_sent,
    output uci_tx_state_t                        state_dbg
);

`ifdef UCI_TX_CRLF_EN
    localparam uci_tx_state_t EOL_FIRST = ST_EOL_CR;
`else
    localparam uci_tx_state_t EOL_FIRST = ST_EOL_LF;
`endif

    // Handshakes: line_in accepted on line_in_valid[i] && line_in_ready[i]; char_out transfers on
    // char_out_valid && char_out_ready, and char_out/char_out_valid stay stable while stalled.
    logic [NUM_CH-1:0][MAX_LEN-1:0][7:0] slot_q;
    logic [NUM_CH-1:0]                   full_q, accept;
    logic [MAX_LEN-1:0][7:0]             shift_q, shift_d, shifted;
    uci_tx_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                    active_q, active_d, last_q, last_d;
    logic [7:0]                          char_q, char_d;
    logic                                valid_q, valid_d, eol_q, eol_d, busy_q, busy_d;
    logic [15:0]                         sent_q;
    logic [NUM_CH-1:0]                   grant_oh;
    logic [IDX_W-1:0]                    grant_idx;
    logic                                grant_vld, advance, take, out_hs;

    assign line_in_ready  = ~full_q & {NUM_CH{~rst_in}};
    assign accept         = line_in_valid & ~full_q;
    assign out_hs         = valid_q & char_out_ready;
    assign advance        = (state_q != ST_IDLE) && (!valid_q || char_out_ready);
    assign shifted        = shift_q >> 8;

    assign char_out       = char_q;
    assign char_out_valid = valid_q;
    assign busy           = busy_q;
    assign active_ch      = active_q;
    assign lines_sent     = sent_q;
    assign state_dbg      = state_q;

    rr_arbiter #(
        .NUM_CH        (NUM_CH),
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_arb (
        .req       (full_q),
        .last      (last_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // The FSM feeds a one-entry output register; it advances whenever that register is free or draining.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        active_d = active_q;
        last_d   = last_q;
        char_d   = char_q;
        valid_d  = valid_q && !char_out_ready;
        eol_d    = eol_q && !char_out_ready;
        take     = 1'b0;
        case (state_q)
            ST_IDLE: take = grant_vld;
            ST_SEND: begin
                if (advance) begin
                    char_d  = shift_q[0];
                    valid_d = 1'b1;
                    eol_d   = 1'b0;
                    shift_d = shifted;
                    if (shifted[0] == 8'h00)
                        state_d = EOL_FIRST;
                end
            end
`ifdef UCI_TX_CRLF_EN
            ST_EOL_CR: begin
                if (advance) begin
                    char_d  = CARRIAGE_RET;
                    valid_d = 1'b1;
                    eol_d   = 1'b0;
                    state_d = ST_EOL_LF;
                end
            end
`endif
            ST_EOL_LF: begin
                if (advance) begin
                    char_d  = NEW_LINE;
                    valid_d = 1'b1;
                    eol_d   = 1'b1;
                    state_d = ST_IDLE;
                    take    = grant_vld;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            shift_d  = slot_q[grant_idx];
            active_d = grant_idx;
            last_d   = grant_idx;
            state_d  = (slot_q[grant_idx][0] == 8'h00) ? EOL_FIRST : ST_SEND;
        end
        if (take)
            busy_d = 1'b1;
        else if (out_hs && eol_q && state_q == ST_IDLE)
            busy_d = 1'b0;
        else
            busy_d = busy_q;
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_CH; i++)
            if (accept[i])
                slot_q[i] <= line_in[i];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            full_q   <= '0;
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            active_q <= '0;
            last_q   <= IDX_W'(NUM_CH - 1);
            char_q   <= '0;
            valid_q  <= 1'b0;
            eol_q    <= 1'b0;
            busy_q   <= 1'b0;
            sent_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i])
                    full_q[i] <= 1'b1;
                else if (take && grant_oh[i])
                    full_q[i] <= 1'b0;
            end
            state_q  <= state_d;
            shift_q  <= shift_d;
            active_q <= active_d;
            last_q   <= last_d;
            char_q   <= char_d;
            valid_q  <= valid_d;
            eol_q    <= eol_d;
            busy_q   <= busy_d;
            if (out_hs && eol_q)
                sent_q <= sent_q + 16'd1;
        end
    end

endmodule
